spi_controller: RTL and testbench

//  SPI mode-0 controller (initiator) that drives 16-bit write frames into the spi_peripheral register file.

---
 rtl/spi_controller.sv | 193 +++++++++++++++++++
 tb/tb_spi_controller.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_controller.sv
// SPI mode-0 initiator: one valid/ready request -> one 16-bit nCS-framed write.
// Define SPI_CTRL_READBACK_EN to add CIPO capture of the data phase into rd_data.
module spi_controller #(
  parameter int CLK_DIV = 4,
  parameter int CS_IDLE = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       req_valid,
  output logic       req_ready,
  input  logic       req_write,
  input  logic [6:0] req_addr,
  input  logic [7:0] req_wdata,
  output logic       busy,
  output logic       done,
  output logic       SCLK,
  output logic       COPI,
  output logic       nCS
`ifdef SPI_CTRL_READBACK_EN
  ,
  input  logic       CIPO,
  output logic [7:0] rd_data
`endif
);

  localparam int CMAX = (CLK_DIV > CS_IDLE) ? CLK_DIV : CS_IDLE;
  localparam int CW   = (CMAX > 1) ? $clog2(CMAX) : 1;

  localparam logic [CW-1:0] DIV_LAST = CW'(CLK_DIV - 1);
  localparam logic [CW-1:0] GAP_LAST = CW'(CS_IDLE - 1);
  localparam logic [CW-1:0] GAP_DONE = CW'(CS_IDLE - 2);

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    HIGH,
    LOW,
    HOLD,
    GAP
  } state_e;

  state_e          state_q, state_d;
  logic [CW-1:0]   div_q, div_d;
  logic [4:0]      bit_q, bit_d;
  logic [15:0]     sr_q, sr_d;
  logic            sclk_q, sclk_d;
  logic            copi_q, copi_d;
  logic            ncs_q, ncs_d;
  logic            done_q, done_d;
  logic            rdy_q, rdy_d;
  logic            div_end;

`ifdef SPI_CTRL_READBACK_EN
  logic            cipo_m_q, cipo_s_q;
  logic [7:0]      rsh_q, rsh_d;
  logic [7:0]      rd_q, rd_d;
`endif

  assign div_end = (div_q == DIV_LAST);

  always_comb begin
    state_d = state_q;
    div_d   = div_q + CW'(1);
    bit_d   = bit_q;
    sr_d    = sr_q;
    sclk_d  = sclk_q;
    copi_d  = copi_q;
    ncs_d   = ncs_q;
    done_d  = 1'b0;
    rdy_d   = rdy_q;
`ifdef SPI_CTRL_READBACK_EN
    rsh_d   = rsh_q;
    rd_d    = rd_q;
`endif
    case (state_q)
      IDLE: begin
        div_d = '0;
        if (req_valid) begin
          state_d = SETUP;
          sr_d    = {req_write, req_addr, req_wdata};
          copi_d  = req_write;
          ncs_d   = 1'b0;
          rdy_d   = 1'b0;
          bit_d   = '0;
        end
      end
      SETUP, LOW: begin
        if (div_end) begin
          state_d = HIGH;
          div_d   = '0;
          sclk_d  = 1'b1;
          bit_d   = bit_q + 5'd1;
        end
      end
      HIGH: begin
        if (div_end) begin
          div_d  = '0;
          sclk_d = 1'b0;
`ifdef SPI_CTRL_READBACK_EN
          // bits 8..15 (edges 9..16) carry the peripheral's data byte
          if (bit_q >= 5'd9) rsh_d = {rsh_q[6:0], cipo_s_q};
`endif
          if (bit_q == 5'd16) begin
            state_d = HOLD;
            copi_d  = 1'b0;
          end else begin
            state_d = LOW;
            sr_d    = {sr_q[14:0], 1'b0};
            copi_d  = sr_q[14];
          end
        end
      end
      HOLD: begin
        if (div_end) begin
          state_d = GAP;
          div_d   = '0;
          ncs_d   = 1'b1;
        end
      end
      GAP: begin
        if (div_q == GAP_DONE) begin
          done_d = 1'b1;
`ifdef SPI_CTRL_READBACK_EN
          rd_d   = rsh_q;
`endif
        end
        if (div_q == GAP_LAST) begin
          state_d = IDLE;
          div_d   = '0;
          rdy_d   = 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        div_d   = '0;
        sclk_d  = 1'b0;
        copi_d  = 1'b0;
        ncs_d   = 1'b1;
        rdy_d   = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      div_q   <= '0;
      bit_q   <= '0;
      sr_q    <= '0;
      sclk_q  <= 1'b0;
      copi_q  <= 1'b0;
      ncs_q   <= 1'b1;
      done_q  <= 1'b0;
      rdy_q   <= 1'b1;
    end else begin
      state_q <= state_d;
      div_q   <= div_d;
      bit_q   <= bit_d;
      sr_q    <= sr_d;
      sclk_q  <= sclk_d;
      copi_q  <= copi_d;
      ncs_q   <= ncs_d;
      done_q  <= done_d;
      rdy_q   <= rdy_d;
    end
  end

`ifdef SPI_CTRL_READBACK_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cipo_m_q <= 1'b0;
      cipo_s_q <= 1'b0;
      rsh_q    <= '0;
      rd_q     <= '0;
    end else begin
      cipo_m_q <= CIPO;
      cipo_s_q <= cipo_m_q;
      rsh_q    <= rsh_d;
      rd_q     <= rd_d;
    end
  end

  assign rd_data = rd_q;
`endif

  assign req_ready = rdy_q;
  assign busy      = ~rdy_q;
  assign done      = done_q;
  assign SCLK      = sclk_q;
  assign COPI      = copi_q;
  assign nCS       = ncs_q;

endmodule

// File: tb/tb_spi_controller.sv
// Directed bench for spi_controller: frame content, timing, back-to-back,
// mid-frame reset and (with SPI_CTRL_READBACK_EN) CIPO readback.
module tb_spi_controller;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       req_valid;
  logic       req_ready;
  logic       req_write;
  logic [6:0] req_addr;
  logic [7:0] req_wdata;
  logic       busy;
  logic       done;
  logic       SCLK;
  logic       COPI;
  logic       nCS;
  logic       CIPO;
  logic [7:0] rd_data;

  int checks = 0;
  int errors = 0;

  logic [15:0] cap;
  int          edges;
  int          hi_run;
  int          last_gap;
  logic        cipo_en;
  logic [7:0]  cipo_pat;
  int          lowc;
  int          lat;
  int          g;

  spi_controller #(
    .CLK_DIV(4),
    .CS_IDLE(4)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .req_valid(req_valid),
    .req_ready(req_ready),
    .req_write(req_write),
    .req_addr (req_addr),
    .req_wdata(req_wdata),
    .busy     (busy),
    .done     (done),
    .SCLK     (SCLK),
    .COPI     (COPI),
`ifdef SPI_CTRL_READBACK_EN
    .nCS      (nCS),
    .CIPO     (CIPO),
    .rd_data  (rd_data)
`else
    .nCS      (nCS)
`endif
  );

`ifndef SPI_CTRL_READBACK_EN
  assign rd_data = 8'h00;
`endif

  always #5 clk = ~clk;

  always @(posedge SCLK) begin
    cap   = {cap[14:0], COPI};
    edges = edges + 1;
  end

  // peripheral model: shifts out cipo_pat during the data phase, MSB first
  always @(negedge SCLK) begin
    if (cipo_en && edges >= 8 && edges < 16) CIPO = cipo_pat[15 - edges];
    else CIPO = 1'b0;
  end

  always @(negedge clk) begin
    if (nCS) hi_run = hi_run + 1;
    else begin
      if (hi_run > 0) last_gap = hi_run;
      hi_run = 0;
    end
  end

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // waits for ready, then lets the next edge accept the pending request
  task automatic accept();
    g = 0;
    while (!req_ready && g < 400) begin
      @(posedge clk);
      #1;
      g++;
    end
    cap   = '0;
    edges = 0;
    @(posedge clk);
    #1;
    chk("accept_ncs", {31'd0, nCS}, 32'd0);
  endtask

  // called #1 after the accept edge; returns at the done cycle
  task automatic measure(output int lc, output int lt);
    int n;
    n  = 0;
    lt = -1;
    lc = nCS ? 0 : 1;
    while (lt < 0 && n < 400) begin
      @(posedge clk);
      #1;
      n++;
      if (!nCS) lc++;
      if (done) lt = n + 1;
    end
  endtask

  initial begin
    rst_n     = 1'b0;
    req_valid = 1'b0;
    req_write = 1'b0;
    req_addr  = '0;
    req_wdata = '0;
    CIPO      = 1'b0;
    cipo_en   = 1'b0;
    cipo_pat  = 8'hC3;
    cap       = '0;
    edges     = 0;
    hi_run    = 0;
    last_gap  = 0;

    repeat (3) @(posedge clk);
    #1;
    chk("rst_ncs",   {31'd0, nCS},       32'd1);
    chk("rst_sclk",  {31'd0, SCLK},      32'd0);
    chk("rst_copi",  {31'd0, COPI},      32'd0);
    chk("rst_ready", {31'd0, req_ready}, 32'd1);
    chk("rst_busy",  {31'd0, busy},      32'd0);
    chk("rst_done",  {31'd0, done},      32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;

    // single write frame 0x8480
    req_valid = 1'b1;
    req_write = 1'b1;
    req_addr  = 7'h04;
    req_wdata = 8'h80;
    accept();
    req_valid = 1'b0;
    chk("f1_busy", {31'd0, busy}, 32'd1);
    measure(lowc, lat);
    chk("f1_copi",  {16'd0, cap}, 32'h8480);
    chk("f1_edges", edges,        32'd16);
    chk("f1_ncslo", lowc,         32'd132);
    chk("f1_lat",   lat,          32'd136);
    @(posedge clk);
    #1;
    chk("f1_ready", {31'd0, req_ready}, 32'd1);
    chk("f1_done1", {31'd0, done},      32'd0);

    // back-to-back with req_valid held high
    req_valid = 1'b1;
    req_write = 1'b1;
    req_addr  = 7'h01;
    req_wdata = 8'h3C;
    accept();
    req_addr  = 7'h02;
    req_wdata = 8'hFF;
    measure(lowc, lat);
    chk("b1_copi", {16'd0, cap}, 32'h813C);
    chk("b1_lat",  lat,          32'd136);
    @(posedge clk);
    #1;
    chk("b2_ready", {31'd0, req_ready}, 32'd1);
    accept();
    req_valid = 1'b0;
    measure(lowc, lat);
    chk("b2_copi",  {16'd0, cap}, 32'h82FF);
    chk("b2_edges", edges,        32'd16);
    chk("b2_gap",   last_gap,     32'd5);

    // reset after the 8th rising edge
    repeat (3) @(posedge clk);
    #1;
    req_valid = 1'b1;
    req_write = 1'b1;
    req_addr  = 7'h11;
    req_wdata = 8'h22;
    accept();
    req_valid = 1'b0;
    g = 0;
    while (edges < 8 && g < 400) begin
      @(posedge clk);
      #1;
      g++;
    end
    chk("rs_edges", edges, 32'd8);
    rst_n = 1'b0;
    #1;
    chk("rs_ncs",   {31'd0, nCS},       32'd1);
    chk("rs_sclk",  {31'd0, SCLK},      32'd0);
    chk("rs_copi",  {31'd0, COPI},      32'd0);
    chk("rs_ready", {31'd0, req_ready}, 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // read-flagged frame after reset: rw bit 0 still shifted
    req_valid = 1'b1;
    req_write = 1'b0;
    req_addr  = 7'h7F;
    req_wdata = 8'h55;
    accept();
    req_valid = 1'b0;
    measure(lowc, lat);
    chk("f4_copi",  {16'd0, cap}, 32'h7F55);
    chk("f4_edges", edges,        32'd16);
    chk("f4_ncslo", lowc,         32'd132);
    chk("f4_lat",   lat,          32'd136);

`ifdef SPI_CTRL_READBACK_EN
    @(posedge clk);
    #1;
    chk("rb_init", {24'd0, rd_data}, 32'h00);
    cipo_en   = 1'b1;
    req_valid = 1'b1;
    req_write = 1'b0;
    req_addr  = 7'h00;
    req_wdata = 8'h00;
    accept();
    req_valid = 1'b0;
    measure(lowc, lat);
    chk("rb_data", {24'd0, rd_data}, 32'hC3);
    cipo_en = 1'b0;
    @(posedge clk);
    #1;
    req_valid = 1'b1;
    req_addr  = 7'h04;
    accept();
    req_valid = 1'b0;
    repeat (60) @(posedge clk);
    #1;
    chk("rb_hold", {24'd0, rd_data}, 32'hC3);
    measure(lowc, lat);
    chk("rb_next", {24'd0, rd_data}, 32'h00);
`endif

    repeat (4) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
